// File: rtl/pc_sequencer.sv
// Program-counter fetch/issue sequencer with redirect, stall and halt handling.
// Optional PC_ALIGN_CHECK_EN: misaligned redirect targets halt the core and raise sticky misalign.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clka,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
`ifdef PC_ALIGN_CHECK_EN
    output logic        misalign,
`endif
    output logic        halted
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    function automatic logic [31:0] pc_step_f(input logic [31:0] pc);
        return pc + 32'(PC_STEP);
    endfunction

    state_t      state_r, next_state_s;
    logic [31:0] pc_r, pc_nxt_s;
    logic [31:0] tgt_r, tgt_nxt_s;
    logic        kill_r, kill_nxt_s;
    logic        hpend_r, hpend_nxt_s;
    logic        cap_s;
    logic [31:0] instr_r, instr_pc_r;
    logic        imem_req_r, imem_req_s;
    logic        issue_r, issue_s;
    logic        halted_r, halted_s;
    logic        bad_tgt_s, halt_eff_s, redir_s;

`ifdef PC_ALIGN_CHECK_EN
    function automatic logic misaligned_f(input logic [31:0] t);
        return t[1:0] != 2'b00;
    endfunction

    logic misalign_r;

    assign bad_tgt_s = redirect & misaligned_f(redirect_target);
    assign misalign  = misalign_r;

    // Sticky misalign flag; a bad target is only honoured where halt would be.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            misalign_r <= 1'b0;
        end else if (bad_tgt_s && (state_r != ST_HALT)) begin
            misalign_r <= 1'b1;
        end else begin
            misalign_r <= misalign_r;
        end
    end
`else
    assign bad_tgt_s = 1'b0;
`endif

    // A misaligned redirect behaves as a halt and never as a redirect.
    assign halt_eff_s = halt | bad_tgt_s;
    assign redir_s    = redirect & ~bad_tgt_s;

    // State, PC bookkeeping and registered outputs.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            tgt_r      <= 32'h0000_0000;
            kill_r     <= 1'b0;
            hpend_r    <= 1'b0;
            instr_r    <= 32'h0000_0000;
            instr_pc_r <= 32'h0000_0000;
            imem_req_r <= 1'b0;
            issue_r    <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            pc_r       <= pc_nxt_s;
            tgt_r      <= tgt_nxt_s;
            kill_r     <= kill_nxt_s;
            hpend_r    <= hpend_nxt_s;
            instr_r    <= cap_s ? imem_rdata : instr_r;
            instr_pc_r <= cap_s ? pc_r : instr_pc_r;
            imem_req_r <= imem_req_s;
            issue_r    <= issue_s;
            halted_r   <= halted_s;
        end
    end

    // Next-state and datapath update; priority halt > redirect > normal flow.
    always_comb begin
        next_state_s = state_r;
        pc_nxt_s     = pc_r;
        tgt_nxt_s    = tgt_r;
        kill_nxt_s   = kill_r;
        hpend_nxt_s  = hpend_r;
        cap_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (halt_eff_s) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (halt_eff_s) begin
                    next_state_s = ST_HALT;
                end else if (redir_s) begin
                    next_state_s = ST_FETCH;
                    pc_nxt_s     = redirect_target;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    kill_nxt_s  = 1'b0;
                    hpend_nxt_s = 1'b0;
                    if (halt_eff_s || hpend_r) begin
                        next_state_s = ST_HALT;
                    end else if (redir_s) begin
                        next_state_s = ST_FETCH;
                        pc_nxt_s     = redirect_target;
                    end else if (kill_r) begin
                        next_state_s = ST_FETCH;
                        pc_nxt_s     = tgt_r;
                    end else begin
                        next_state_s = ST_ISSUE;
                        cap_s        = 1'b1;
                    end
                end else begin
                    // The bus request stays on the old address; only remember where to go.
                    if (halt_eff_s) begin
                        hpend_nxt_s = 1'b1;
                    end else if (redir_s && !hpend_r) begin
                        tgt_nxt_s  = redirect_target;
                        kill_nxt_s = 1'b1;
                    end else begin
                        hpend_nxt_s = hpend_r;
                    end
                end
            end
            ST_ISSUE: begin
                if (halt_eff_s) begin
                    next_state_s = ST_HALT;
                end else if (redir_s) begin
                    next_state_s = ST_FETCH;
                    pc_nxt_s     = redirect_target;
                end else if (stall) begin
                    next_state_s = ST_ISSUE;
                end else begin
                    next_state_s = ST_FETCH;
                    pc_nxt_s     = pc_step_f(pc_r);
                end
            end
            ST_HALT: begin
                next_state_s = ST_HALT;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the outputs can be registered.
    always_comb begin
        imem_req_s = 1'b0;
        issue_s    = 1'b0;
        halted_s   = 1'b0;
        case (next_state_s)
            ST_FETCH, ST_WAIT: imem_req_s = 1'b1;
            ST_ISSUE:          issue_s    = 1'b1;
            ST_HALT:           halted_s   = 1'b1;
            default:           imem_req_s = 1'b0;
        endcase
    end

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign halted      = halted_r;
    // Issue handshake must react to stall/redirect/halt in the same cycle.
    assign instr_valid = issue_r & ~stall & ~redirect & ~halt_eff_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with a latency-programmable memory model.
module tb_pc_sequencer;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clka = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;
`ifdef PC_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int ack_delay    = 1;
    int mem_cnt;
    int n;

    pc_sequencer dut (
        .clka            (clka),
        .reset_n         (reset_n),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .halt            (halt),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
`ifdef PC_ALIGN_CHECK_EN
        .misalign        (misalign),
`endif
        .halted          (halted)
    );

    always #5 clka = ~clka;

    // Memory: ack once the request has been held for ack_delay edges.
    always @(posedge clka or negedge reset_n) begin
        if (!reset_n) mem_cnt <= 0;
        else if (!imem_req || imem_ack) mem_cnt <= 0;
        else mem_cnt <= mem_cnt + 1;
    end
    assign imem_ack   = imem_req && (mem_cnt >= ack_delay);
    assign imem_rdata = imem_addr ^ KEY;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clka);
        #1;
    endtask

    task automatic wait_valid(input string tag, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < 20) begin
            cyc();
            cycles++;
            if (instr_valid) found = 1'b1;
        end
        check_val({tag, "_found"}, {31'b0, found}, 32'd1);
    endtask

    task automatic wait_pc(input string tag, input logic [31:0] pc);
        int k;
        k = 0;
        while (instr_pc !== pc && k < 20) begin
            cyc();
            k++;
        end
        check_val({tag, "_reach"}, instr_pc, pc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_target = 32'h0; halt = 1'b0;
        repeat (3) cyc();
        check_val("rst_req", {31'b0, imem_req}, 32'd0);
        check_val("rst_valid", {31'b0, instr_valid}, 32'd0);
        check_val("rst_halted", {31'b0, halted}, 32'd0);
        check_val("rst_instr", instr, 32'h0);
        check_val("rst_instr_pc", instr_pc, 32'h0);
        check_val("rst_addr", imem_addr, 32'h0);

        // Release: IDLE cycle, then FETCH.
        reset_n = 1'b1;
        #1;
        check_val("idle_req", {31'b0, imem_req}, 32'd0);
        cyc();
        check_val("fetch0_req", {31'b0, imem_req}, 32'd1);
        check_val("fetch0_addr", imem_addr, 32'h0);
        wait_valid("v0", n);
        check_val("lat0", n, 32'd2);
        check_val("v0_pc", instr_pc, 32'h0);
        check_val("v0_instr", instr, 32'h0 ^ KEY);
        wait_valid("v4", n);
        check_val("gap4", n, 32'd3);
        check_val("v4_pc", instr_pc, 32'h4);

        // Stall five cycles while holding pc 0x8.
        cyc();
        stall = 1'b1;
        #1;
        wait_pc("st8", 32'h8);
        check_val("st_v0", {31'b0, instr_valid}, 32'd0);
        for (int i = 1; i < 5; i++) begin
            cyc();
            check_val("st_v", {31'b0, instr_valid}, 32'd0);
            check_val("st_hold_pc", instr_pc, 32'h8);
            check_val("st_hold_instr", instr, 32'h8 ^ KEY);
        end
        cyc();
        stall = 1'b0;
        #1;
        check_val("st_issue", {31'b0, instr_valid}, 32'd1);
        check_val("st_issue_pc", instr_pc, 32'h8);
        ack_delay = 3;
        cyc();
        check_val("fetchC_addr", imem_addr, 32'hC);
        check_val("fetchC_req", {31'b0, imem_req}, 32'd1);

        // Redirect inside WAIT kills the in-flight fetch.
        cyc();
        redirect = 1'b1; redirect_target = 32'h40;
        #1;
        check_val("kw_addr1", imem_addr, 32'hC);
        check_val("kw_v1", {31'b0, instr_valid}, 32'd0);
        cyc();
        redirect = 1'b0;
        check_val("kw_addr2", imem_addr, 32'hC);
        check_val("kw_req2", {31'b0, imem_req}, 32'd1);
        cyc();
        check_val("kw_ack", {31'b0, imem_ack}, 32'd1);
        check_val("kw_addr3", imem_addr, 32'hC);
        cyc();
        ack_delay = 1;
        check_val("kw_new_addr", imem_addr, 32'h40);
        check_val("kw_new_req", {31'b0, imem_req}, 32'd1);
        check_val("kw_no_cap", instr_pc, 32'h8);
        check_val("kw_v4", {31'b0, instr_valid}, 32'd0);
        wait_valid("v40", n);
        check_val("v40_pc", instr_pc, 32'h40);
        check_val("v40_instr", instr, 32'h40 ^ KEY);

        // Redirect in a stalled ISSUE squashes the held instruction.
        cyc();
        stall = 1'b1;
        #1;
        wait_pc("ri44", 32'h44);
        redirect = 1'b1; redirect_target = 32'h100;
        #1;
        check_val("ri_v", {31'b0, instr_valid}, 32'd0);
        cyc();
        redirect = 1'b0; stall = 1'b0;
        check_val("ri_addr", imem_addr, 32'h100);
        check_val("ri_req", {31'b0, imem_req}, 32'd1);

        // Redirect coinciding with ack.
        cyc();
        redirect = 1'b1; redirect_target = 32'h200;
        #1;
        check_val("ra_v", {31'b0, instr_valid}, 32'd0);
        cyc();
        redirect = 1'b0;
        check_val("ra_addr", imem_addr, 32'h200);
        check_val("ra_no_cap", instr_pc, 32'h44);

        // Two redirects in one WAIT: the last target wins.
        ack_delay = 3;
        cyc();
        redirect = 1'b1; redirect_target = 32'h300;
        cyc();
        redirect_target = 32'h400;
        check_val("lw_addr", imem_addr, 32'h200);
        cyc();
        redirect = 1'b0;
        cyc();
        ack_delay = 1;
        check_val("lw_target", imem_addr, 32'h400);

        // Address wrap at the top of the space.
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        cyc();
        redirect = 1'b0;
        check_val("wr_addr", imem_addr, 32'hFFFF_FFFC);
        wait_valid("vwrap", n);
        check_val("wr_pc", instr_pc, 32'hFFFF_FFFC);
        cyc();
        check_val("wr_next", imem_addr, 32'h0);

        // Halt during WAIT waits for the ack.
        ack_delay = 3;
        cyc();
        halt = 1'b1;
        cyc();
        check_val("hw_halted1", {31'b0, halted}, 32'd0);
        cyc();
        check_val("hw_halted2", {31'b0, halted}, 32'd0);
        check_val("hw_req2", {31'b0, imem_req}, 32'd1);
        cyc();
        check_val("hw_halted3", {31'b0, halted}, 32'd1);
        check_val("hw_req3", {31'b0, imem_req}, 32'd0);
        check_val("hw_v3", {31'b0, instr_valid}, 32'd0);
        redirect = 1'b1; redirect_target = 32'h500;
        cyc();
        halt = 1'b0; redirect = 1'b0;
        cyc();
        check_val("hw_stay", {31'b0, halted}, 32'd1);
        check_val("hw_stay_req", {31'b0, imem_req}, 32'd0);
        check_val("hw_ign_redir", imem_addr, 32'h0);

        // Leave HALT by reset, then reset again in the middle of WAIT.
        reset_n = 1'b0;
        #1;
        check_val("rh_halted", {31'b0, halted}, 32'd0);
        cyc();
        reset_n = 1'b1;
        ack_delay = 1;
        cyc();
        wait_valid("rv0", n);
        ack_delay = 3;
        cyc();
        check_val("rm_addr4", imem_addr, 32'h4);
        cyc();
        reset_n = 1'b0;
        #1;
        check_val("rm_req", {31'b0, imem_req}, 32'd0);
        check_val("rm_addr", imem_addr, 32'h0);
        check_val("rm_v", {31'b0, instr_valid}, 32'd0);
        cyc();
        reset_n = 1'b1;
        ack_delay = 1;
        #1;
        check_val("rm_idle", {31'b0, imem_req}, 32'd0);
        cyc();
        check_val("rm_refetch", imem_addr, 32'h0);
        check_val("rm_refetch_req", {31'b0, imem_req}, 32'd1);
        wait_valid("rv1", n);
        check_val("rm_lat", n, 32'd2);
        check_val("rm_pc", instr_pc, 32'h0);

        // Redirect to a misaligned target from FETCH.
        cyc();
        redirect = 1'b1; redirect_target = 32'h42;
        cyc();
        redirect = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        check_val("al_misalign", {31'b0, misalign}, 32'd1);
        check_val("al_halted", {31'b0, halted}, 32'd1);
        check_val("al_req", {31'b0, imem_req}, 32'd0);
        check_val("al_pc", imem_addr, 32'h4);
        cyc();
        check_val("al_sticky", {31'b0, misalign}, 32'd1);
`else
        check_val("al_accept", imem_addr, 32'h42);
        check_val("al_req", {31'b0, imem_req}, 32'd1);
        check_val("al_halted", {31'b0, halted}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
